// File: rtl/multi_link_buffer_if.sv
// Bundle of the link-side and consumer-side handshake/bus signals of multi_link_buffer.
// The buffer uses the slave modport and the producer/consumer side uses the master modport.
interface multi_link_buffer_if #(
  parameter int DATA_WIDTH = 40,
  parameter int DATA_DEPTH = 4096,
  parameter int NUM_LINKS  = 4
) ();
  localparam int LINK_W = $clog2(NUM_LINKS);
  localparam int CNT_W  = $clog2(DATA_DEPTH) + 1;

  logic [NUM_LINKS-1:0]            in_valid;
  logic [NUM_LINKS*DATA_WIDTH-1:0] in_data;
  logic [NUM_LINKS-1:0]            in_ready;
  logic                            out_valid;
  logic                            out_ready;
  logic [DATA_WIDTH-1:0]           out_data;
  logic [LINK_W-1:0]               out_link;
  logic [CNT_W-1:0]                count;
  logic                            full;
  logic                            almost_full;
  logic                            empty;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_link, count, full, almost_full, empty
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_link, count, full, almost_full, empty
  );
endinterface

// File: rtl/multi_link_buffer.sv
// N-link ingress buffer: arbitrated links feed one circular FIFO drained through a registered
// first-word-fall-through output stage tagged with the source link. Optional stats: BUFFER_STATS_EN.
module multi_link_buffer #(
  parameter int DATA_WIDTH = 40,
  parameter int DATA_DEPTH = 4096,
  parameter int NUM_LINKS  = 4,
  parameter int AFULL_LVL  = 4092
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        arb_mode,
  multi_link_buffer_if.slave          bus
`ifdef BUFFER_STATS_EN
  ,
  output logic [$clog2(DATA_DEPTH):0] stat_hwm,
  output logic [15:0]                 stat_stall
`endif
);
  localparam int LINK_W = $clog2(NUM_LINKS);
  localparam int AW     = $clog2(DATA_DEPTH);
  localparam int CW     = AW + 1;
  localparam int EW     = LINK_W + DATA_WIDTH;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // Upstream, in_ready is a one-hot grant; downstream, out_valid/out_data/out_link hold until taken.

  logic [NUM_LINKS-1:0]  grant;
  logic [LINK_W-1:0]     grant_idx;
  logic [LINK_W-1:0]     rr_idx;
  logic                  found;

  logic [LINK_W-1:0]     rr_last_q, rr_last_d;
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d;
  logic                  full_q, afull_q, empty_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [LINK_W-1:0]     out_link_q;
  logic [EW-1:0]         mem_q [DATA_DEPTH];

  logic                  push, pop, load;
  logic [EW-1:0]         wr_entry, rd_entry;

  // Grant uses the registered full flag, so a pop in the same cycle never reopens the inputs.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    rr_idx    = '0;
    found     = 1'b0;
    if (rst && !full_q) begin
      if (arb_mode) begin
        for (int i = NUM_LINKS - 1; i >= 0; i--) begin
          if (bus.in_valid[LINK_W'(i)]) begin
            grant_idx = LINK_W'(i);
            found     = 1'b1;
          end
        end
      end else begin
        for (int k = 1; k <= NUM_LINKS; k++) begin
          rr_idx = LINK_W'((int'(rr_last_q) + k) % NUM_LINKS);
          if (!found && bus.in_valid[rr_idx]) begin
            grant_idx = rr_idx;
            found     = 1'b1;
          end
        end
      end
      if (found) grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    push       = found;
    pop        = out_valid_q & bus.out_ready;
    load       = (!out_valid_q || pop) && (fifo_cnt_q != '0);
    wr_entry   = {grant_idx, bus.in_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH]};
    rd_entry   = mem_q[rd_ptr_q];
    count_d    = count_q + CW'(push) - CW'(pop);
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(load);
    rr_last_d  = (push && !arb_mode) ? grant_idx : rr_last_q;
  end

  // Storage array carries no reset; pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last_q   <= LINK_W'(NUM_LINKS - 1);
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_cnt_q  <= '0;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      empty_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_link_q  <= '0;
    end else begin
      rr_last_q  <= rr_last_d;
      count_q    <= count_d;
      fifo_cnt_q <= fifo_cnt_d;
      full_q     <= (count_d == CW'(DATA_DEPTH));
      afull_q    <= (count_d >= CW'(AFULL_LVL));
      empty_q    <= (count_d == '0);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (load) begin
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        out_valid_q <= 1'b1;
        out_data_q  <= rd_entry[DATA_WIDTH-1:0];
        out_link_q  <= rd_entry[EW-1:DATA_WIDTH];
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = grant;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_link    = out_link_q;
  assign bus.count       = count_q;
  assign bus.full        = full_q;
  assign bus.almost_full = afull_q;
  assign bus.empty       = empty_q;

`ifdef BUFFER_STATS_EN
  logic [CW-1:0] hwm_q;
  logic [15:0]   stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hwm_q   <= '0;
      stall_q <= '0;
    end else begin
      if (count_d > hwm_q) hwm_q <= count_d;
      if ((|bus.in_valid) && full_q && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
    end
  end

  assign stat_hwm   = hwm_q;
  assign stat_stall = stall_q;
`endif
endmodule
